// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, default latencies and the unit's state type.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MFHI     = 4'd5,
        MFLO     = 4'd6,
        MTHI     = 4'd7,
        MTLO     = 4'd8
    } mdu_op_e;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_e;

    // True for the ops that launch a multi-cycle operation.
    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU signal bundle: op/operands in, status and HI/LO out.
interface e_mdu_if;

    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_rd;

    modport master (
        output mdu_op, rs_val, rt_val,
        input  start, busy, hi, lo, mdu_rd
    );

    modport slave (
        input  mdu_op, rs_val, rt_val,
        output start, busy, hi, lo, mdu_rd
    );

endinterface

// File: rtl/e_mdu_divider.sv
// Combinational 32-bit divider, signed or unsigned. Quotient truncates
// toward zero and the remainder follows the dividend's sign.
module mdu_divider (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;

    // Divide magnitudes, then restore signs. INT_MIN has magnitude
    // 0x80000000, so INT_MIN / -1 yields 0x80000000 with remainder 0
    // without any special case.
    always_comb begin
        neg_a       = is_signed & dividend[31];
        neg_b       = is_signed & divisor[31];
        mag_a       = neg_a ? -dividend : dividend;
        mag_b       = neg_b ? -divisor  : divisor;
        div_by_zero = (divisor == '0);
        uq          = '0;
        ur          = '0;
        if (!div_by_zero) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        quotient  = (neg_a ^ neg_b) ? -uq : uq;
        remainder = neg_a ? -ur : ur;
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. Owns HI/LO, models latency with a
// busy counter, and commits results when the counter expires.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    mdu_op_e            op;
    logic               start;
    logic               is_mult;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic               div_zero;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    assign op      = mdu_op_e'(bus.mdu_op);
    assign start   = (state_q == ST_IDLE) && is_start_op(bus.mdu_op);
    assign is_mult = (op == MULT) || (op == MULTU);

    assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                    $signed({{32{bus.rt_val[31]}}, bus.rt_val});
    assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

    mdu_divider u_div (
        .dividend    (bus.rs_val),
        .divisor     (bus.rt_val),
        .is_signed   (op == DIV),
        .quotient    (quot),
        .remainder   (rem),
        .div_by_zero (div_zero)
    );

    // Select the result to park in pending; a zero divisor parks the
    // current HI/LO so the commit leaves them unchanged.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MULT:      {res_hi, res_lo} = prod_s;
            MULTU:     {res_hi, res_lo} = prod_u;
            DIV, DIVU: {res_hi, res_lo} = div_zero ? {hi_q, lo_q} : {rem, quot};
            default:   {res_hi, res_lo} = '0;
        endcase
    end

    // Next-state: launch from IDLE, count down in RUN, commit on expiry.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    count_d   = is_mult ? MULT_LOAD : DIV_LOAD;
                    state_d   = ST_RUN;
                end else if (op == MTHI) begin
                    hi_d = bus.rs_val;
                end else if (op == MTLO) begin
                    lo_d = bus.rs_val;
                end
            end
            ST_RUN: begin
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Read port for mfhi/mflo; returns current contents even while busy.
    always_comb begin
        bus.mdu_rd = '0;
        if (op == MFHI) begin
            bus.mdu_rd = hi_q;
        end else if (op == MFLO) begin
            bus.mdu_rd = lo_q;
        end
    end

    assign bus.start = start;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, arithmetic results, busy-time
// blocking, divide by zero and asynchronous reset.
module tb_e_mdu;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   n;

    e_mdu_if u_if ();

    e_mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        u_if.mdu_op = op;
        u_if.rs_val = rs;
        u_if.rt_val = rt;
    endtask

    // Present a start op for one edge, checking start, then drop to NONE.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        drive(op, rs, rt);
        #1;
        check({tag, "_start"}, 32'(u_if.start), 32'd1);
        tick();
        drive(MDU_NONE, '0, '0);
        #1;
    endtask

    // Count cycles busy stays high, bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (u_if.busy === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive(MDU_NONE, '0, '0);
        #1 reset = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_hi", u_if.hi, 32'h0);
        check("rst_lo", u_if.lo, 32'h0);
        check("rst_start", 32'(u_if.start), 32'd0);
        #2 reset = 1'b1;
        tick();

        // MULT -1 * 2
        issue("mult", MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_start_drop", 32'(u_if.start), 32'd0);
        wait_idle(n);
        check("mult_busy_cycles", 32'(n), 32'd5);
        check("mult_hi", u_if.hi, 32'hFFFF_FFFF);
        check("mult_lo", u_if.lo, 32'hFFFF_FFFE);

        // MULTU 0xFFFFFFFF * 2
        issue("multu", MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(n);
        check("multu_busy_cycles", 32'(n), 32'd5);
        check("multu_hi", u_if.hi, 32'h0000_0001);
        check("multu_lo", u_if.lo, 32'hFFFF_FFFE);

        // DIV -7 / 2 = -3 rem -1
        issue("div", DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle(n);
        check("div_busy_cycles", 32'(n), 32'd10);
        check("div_lo", u_if.lo, 32'hFFFF_FFFD);
        check("div_hi", u_if.hi, 32'hFFFF_FFFF);

        // DIV INT_MIN / -1
        issue("divmin", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divmin_lo", u_if.lo, 32'h8000_0000);
        check("divmin_hi", u_if.hi, 32'h0000_0000);

        // DIVU 100 / 7 = 14 rem 2
        issue("divu", DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_lo", u_if.lo, 32'd14);
        check("divu_hi", u_if.hi, 32'd2);

        // MTHI / MTLO preset
        drive(MTHI, 32'h11, '0);
        #1;
        check("mthi_start", 32'(u_if.start), 32'd0);
        tick();
        check("mthi_busy", 32'(u_if.busy), 32'd0);
        check("mthi_hi", u_if.hi, 32'h11);
        drive(MTLO, 32'h22, '0);
        tick();
        check("mtlo_lo", u_if.lo, 32'h22);
        check("mtlo_hi_kept", u_if.hi, 32'h11);
        drive(MFHI, '0, '0);
        #1;
        check("mfhi_rd", u_if.mdu_rd, 32'h11);
        drive(MFLO, '0, '0);
        #1;
        check("mflo_rd", u_if.mdu_rd, 32'h22);

        // Unknown op: no state change
        drive(4'hF, 32'h5555_5555, 32'h3);
        #1;
        check("unk_start", 32'(u_if.start), 32'd0);
        check("unk_rd", u_if.mdu_rd, 32'h0);
        tick();
        check("unk_busy", 32'(u_if.busy), 32'd0);
        check("unk_hi", u_if.hi, 32'h11);
        check("unk_lo", u_if.lo, 32'h22);
        drive(MDU_NONE, '0, '0);
        tick();

        // DIVU by zero keeps HI/LO
        issue("divz", DIVU, 32'h1234, 32'h0);
        wait_idle(n);
        check("divz_busy_cycles", 32'(n), 32'd10);
        check("divz_hi", u_if.hi, 32'h11);
        check("divz_lo", u_if.lo, 32'h22);

        // MULT with MTHI, MFHI and DIV attempted while busy
        issue("blk", MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        tick();
        drive(MTHI, 32'hDEAD, '0);
        #1;
        check("blk_mthi_start", 32'(u_if.start), 32'd0);
        tick();
        check("blk_hi_unchanged", u_if.hi, 32'h11);
        drive(MFHI, '0, '0);
        #1;
        check("blk_mfhi_stale", u_if.mdu_rd, 32'h11);
        drive(DIV, 32'd100, 32'd3);
        #1;
        check("blk_div_start", 32'(u_if.start), 32'd0);
        check("blk_busy", 32'(u_if.busy), 32'd1);
        tick();
        drive(MDU_NONE, '0, '0);
        wait_idle(n);
        check("blk_remaining_cycles", 32'(n), 32'd2);
        check("blk_hi", u_if.hi, 32'hFFFF_FFFF);
        check("blk_lo", u_if.lo, 32'hFFFF_FFFE);

        // Reset mid-run aborts asynchronously
        issue("rstrun", MULTU, 32'd3, 32'd4);
        tick();
        tick();
        check("rstrun_busy_before", 32'(u_if.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstrun_busy", 32'(u_if.busy), 32'd0);
        check("rstrun_hi", u_if.hi, 32'h0);
        check("rstrun_lo", u_if.lo, 32'h0);
        tick();
        check("rstrun_hold_busy", 32'(u_if.busy), 32'd0);
        #2 reset = 1'b1;
        drive(MFHI, '0, '0);
        #1;
        check("rstrun_mfhi", u_if.mdu_rd, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        check("rstrun_after_busy", 32'(u_if.busy), 32'd0);
        check("rstrun_after_lo", u_if.lo, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It consumes operands and the decoded MDU op that the D->E pipeline register presents in E.
- It owns the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- It exposes busy and start so the hazard unit can stall MDU instructions in D.
- It supplies the mfhi/mflo read value to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (>=1).
- DIV_CYCLES, 10, busy duration for div/divu (>=1).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- mdu_op  in  4  decoded op for the instruction in E (encodings in package).
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- start  out  1  combinational; high when mdu_op is MULT/MULTU/DIV/DIVU and the unit is not busy.
- busy  out  1  registered; high while an operation is in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- mdu_rd  out  32  combinational; hi when mdu_op=MFHI, lo when mdu_op=MFLO, else 0.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, count=0, hi=0, lo=0, pending_hi=0, pending_lo=0. Outputs hold these values for as long as reset is low.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, count>0).
- IDLE, start=1 at edge t:
  - Compute the result from rs_val/rt_val and latch it into pending_hi/pending_lo.
  - Load count with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1 from cycle t+1.
- RUN: count decrements each edge. On the edge where count goes 1->0:
  - busy clears.
  - hi/lo take pending values.
  - Net effect: busy is high for exactly N cycles; the new hi/lo are visible in the same cycle busy first reads 0.
- MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
- MULTU: same as MULT, unsigned.
- DIV: signed division, quotient truncated toward zero.
  - lo = quotient; hi = remainder; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned division; lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU, rt_val=0):
  - busy runs the full DIV_CYCLES.
  - hi/lo are left unchanged: pending is loaded with the current hi/lo.
- MTHI/MTLO in IDLE: hi (resp. lo) <= rs_val at the edge, single cycle, busy stays 0.
- MTHI/MTLO while busy: ignored. The hazard unit prevents this; the block must still not corrupt state.
- start conditions while busy: start=0 and the op is ignored. The in-flight operation is not restarted or aborted.
- mfhi/mflo while busy: mdu_rd returns the current (stale) hi/lo. Stalling is the hazard unit's duty.
- MDU_NONE or unknown op: no state change.
- Reset asserted mid-RUN: the operation is aborted, and everything returns to reset values immediately.

Decomposition:
- Package mdu_pkg holds:
  - 4-bit op constants: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - Default cycle-count constants.
- Sub-module mdu_divider: combinational signed/unsigned quotient/remainder with the INT_MIN/-1 and zero-divisor rules.
- Multiply stays inline.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> start=1 for one cycle, busy high exactly 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
- MULTU with the same operands -> hi=0x00000001 lo=0xFFFFFFFE after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU by rt=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> busy 10 cycles, hi/lo still 0x11/0x22.
- MULT issued, then at busy cycle 2 drive MTHI 0xDEAD and a second DIV -> both ignored (start=0), and the final hi/lo match the MULT result.
- reset pulled low during busy cycle 3 -> busy=0 and hi=lo=0 asynchronously; after release, mfhi gives mdu_rd=0.
